fir_tcdm_rr_arbiter: RTL
========================

// Module: fir_tcdm_rr_arbiter
// PURPOSE
// - Shares one HCI-style TCDM master port between NR FIR streamer requesters (e.g. x-in, h-in, y-out).
// - Round-robin arbitration; in-order response routing via outstanding-ID FIFO.
// - Sits between fir_top streamers and one tcdm[] port, so the accelerator runs with MP < number of streams.
// PARAMETERS
// NR        3   number of requesters (>=2)
// AW        32  address width
// DW        32  data width (BE width = DW/8)
// MAX_OUTST 4   max in-flight transactions = ID FIFO depth (power of 2, >=2)
// CNT_W     16  stall counter width (FIR_TCDM_ARB_STALL_CNT_EN only)
// PORTS
// clk_i          in   1            clock
// rst_ni         in   1            asynchronous reset, active-low
// clear_i        in   1            synchronous soft clear
// in_req_i       in   NR           requester req
// in_gnt_o       out  NR           requester gnt
// in_add_i       in   NR x AW      requester address
// in_wen_i       in   NR           1=read, 0=write
// in_be_i        in   NR x DW/8    byte enables
// in_data_i      in   NR x DW      write data
// in_r_data_o    out  NR x DW      response data (broadcast)
// in_r_valid_o   out  NR           response valid (one-hot)
// out_req_o      out  1            TCDM req
// out_gnt_i      in   1            TCDM gnt
// out_add_o      out  AW           TCDM address
// out_wen_o      out  1            TCDM wen
// out_be_o       out  DW/8         TCDM be
// out_data_o     out  DW           TCDM wdata
// out_r_data_i   in   DW           TCDM rdata
// out_r_valid_i  in   1            TCDM r_valid
// busy_o         out  1            FIFO non-empty
// err_o          out  1            sticky: r_valid while FIFO empty
// stall_cnt_o    out  NR x CNT_W   per-requester stall cycles (macro only)
// BEHAVIOUR
// - Reset: rr pointer=0, FIFO empty, err_o=0, counters=0; all outputs 0 (r_data 0 as FIFO empty).
// - Winner w: first i with in_req_i[i]=1 scanning ptr, ptr+1, ... mod NR (combinational).
// - out_req_o = |in_req_i & ~fifo_full; out_add/wen/be/data muxed from w (0 when no req).
// - in_gnt_o[w] = out_gnt_i & out_req_o; all other gnt 0. Request path latency 0 cycles.
// - Master holds req/payload until gnt; arbiter keeps w stable while out_gnt_i=0 (ptr moves only on handshake).
// - Handshake (out_req_o & out_gnt_i): push w into FIFO; ptr <= (w+1) mod NR.
// - Every granted transaction (read or write) returns exactly one out_r_valid_i, in order, latency >=1.
// - out_r_valid_i: pop head h; in_r_valid_o[h]=1 same cycle; in_r_data_o=out_r_data_i. Response latency 0.
// - FIFO full (MAX_OUTST entries): out_req_o=0, no gnt; resumes cycle after a pop.
// - Push+pop same cycle: legal at any level except push when full (masked); count unchanged.
// - r_valid while empty: no in_r_valid_o, err_o <= 1 (held until clear_i/reset).
// - clear_i: ptr, FIFO, err_o, counters -> reset values next edge; has priority over push/pop.
//   In-flight responses after clear are dropped (and flag err_o). Controller clears only when busy_o=0.
// - Async reset mid-transaction: immediate return to reset state; no gnt/r_valid while rst_ni=0.
// - Single requester: back-to-back grants every cycle while out_gnt_i=1 and FIFO not full.
// CONFIGURATION
// - FIR_TCDM_ARB_STALL_CNT_EN defined: stall_cnt_o exists.
//   Per cycle, stall_cnt_o[i]++ when in_req_i[i]=1 & in_gnt_o[i]=0; saturates at 2^CNT_W-1; cleared by clear_i.
// - Not defined: port stall_cnt_o and counter logic absent; all other behaviour identical.
// TESTING
// - Reset, NR=3, all req=1, gnt=1 always, r_valid 1 cycle later -> grants 0,1,2,0,1,2; r_valid one-hot follows same order.
// - req only [1], gnt=1, r_valid never -> 4 grants in 4 cycles, then out_req_o=0, busy_o=1; one r_valid -> grant resumes next cycle.
// - req[0]=req[2]=1, out_gnt_i=0 for 5 cycles -> w=0 stable, ptr=0, no in_gnt; then gnt=1 -> in_gnt_o=3'b001, next winner 2.
// - Push and pop same cycle at 2 entries -> count stays 2; r_data 0xDEADBEEF routed to head ID only.
// - out_r_valid_i with FIFO empty -> no in_r_valid_o, err_o=1; clear_i -> err_o=0, ptr=0.
// - FIR_TCDM_ARB_STALL_CNT_EN, CNT_W=4, req[2] held with out_gnt_i=0 for 20 cycles -> stall_cnt_o[2]=15 (saturated).

Source files
------------

// File: rtl/fir_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port between NR FIR streamers,
// with in-order response routing via an outstanding-ID FIFO. Optional per-requester
// stall counters are enabled with FIR_TCDM_ARB_STALL_CNT_EN.
`ifdef FIR_TCDM_ARB_STALL_CNT_EN
module fir_tcdm_arb_stall_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_o <= '0;
    else if (clear_i)             cnt_o <= '0;
    else if (stall_i && ~&cnt_o)  cnt_o <= cnt_o + 1'b1;
  end
endmodule
`endif

module fir_tcdm_rr_arbiter #(
  parameter int NR        = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [NR-1:0]              in_req_i,
  output logic [NR-1:0]              in_gnt_o,
  input  logic [NR-1:0][AW-1:0]      in_add_i,
  input  logic [NR-1:0]              in_wen_i,
  input  logic [NR-1:0][DW/8-1:0]    in_be_i,
  input  logic [NR-1:0][DW-1:0]      in_data_i,
  output logic [NR-1:0][DW-1:0]      in_r_data_o,
  output logic [NR-1:0]              in_r_valid_o,
  output logic                       out_req_o,
  input  logic                       out_gnt_i,
  output logic [AW-1:0]              out_add_o,
  output logic                       out_wen_o,
  output logic [DW/8-1:0]            out_be_o,
  output logic [DW-1:0]              out_data_o,
  input  logic [DW-1:0]              out_r_data_i,
  input  logic                       out_r_valid_i,
  output logic                       busy_o,
  output logic                       err_o
`ifdef FIR_TCDM_ARB_STALL_CNT_EN
  ,
  output logic [NR-1:0][CNT_W-1:0]   stall_cnt_o
`endif
);
  localparam int IW = $clog2(NR);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  logic [IW-1:0] ptr_q, win, head;
  logic [IW-1:0] fifo_q [MAX_OUTST];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          any_req, live, full, empty, push, pop;

  // Scan from ptr upward; the first requester found wins.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (!any_req && in_req_i[(int'(ptr_q) + k) % NR]) begin
        any_req = 1'b1;
        win     = IW'((int'(ptr_q) + k) % NR);
      end
    end
  end

  assign full  = (cnt_q == CW'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign live  = any_req & rst_ni;
  assign head  = fifo_q[rd_q];

  assign out_req_o = live & ~full;
  assign push      = out_req_o & out_gnt_i;
  assign pop       = out_r_valid_i & ~empty & rst_ni;
  assign busy_o    = ~empty;

  assign out_add_o  = live ? in_add_i[win]  : '0;
  assign out_wen_o  = live ? in_wen_i[win]  : 1'b0;
  assign out_be_o   = live ? in_be_i[win]   : '0;
  assign out_data_o = live ? in_data_i[win] : '0;

  always_comb begin
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    if (push) in_gnt_o[win]      = 1'b1;
    if (pop)  in_r_valid_o[head] = 1'b1;
    for (int i = 0; i < NR; i++) in_r_data_o[i] = pop ? out_r_data_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_o <= 1'b0;
    end else if (clear_i) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (push) begin
        wr_q  <= wr_q + 1'b1;
        ptr_q <= (win == IW'(NR - 1)) ? '0 : win + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (out_r_valid_i && empty) err_o <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) fifo_q[wr_q] <= win;
  end

`ifdef FIR_TCDM_ARB_STALL_CNT_EN
  fir_tcdm_arb_stall_cnt #(.CNT_W(CNT_W)) u_stall [NR-1:0] (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .stall_i (in_req_i & ~in_gnt_o),
    .cnt_o   (stall_cnt_o)
  );
`endif
endmodule
